// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register writer: FSM states,
// quarter-phase indices and the frame-length helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic W_BIT = 1'b0;

  // Bytes per attempt: address byte, register bytes, data bytes.
  function automatic int frame_bytes(input int reg_bytes, input int data_bytes);
    return 1 + reg_bytes + data_bytes;
  endfunction

endpackage

// File: rtl/i2c_reg_writer_if.sv
// Request/status and open-drain pad signals of the I2C register writer.
// "master" is the writer itself; "slave" is the requester and pad side.
interface i2c_reg_writer_if #(
  parameter int REG_BYTES  = 1,
  parameter int DATA_BYTES = 1
);

  logic                    start;
  logic [6:0]              dev_addr;
  logic [8*REG_BYTES-1:0]  reg_addr;
  logic [8*DATA_BYTES-1:0] wdata;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic                    scl_oe;
  logic                    sda_oe;
  logic                    sda_in;

  modport master (
    input  start, dev_addr, reg_addr, wdata, sda_in,
    output busy, done, error, scl_oe, sda_oe
  );

  modport slave (
    output start, dev_addr, reg_addr, wdata, sda_in,
    input  busy, done, error, scl_oe, sda_oe
  );

endinterface

// File: rtl/i2c_qtick.sv
// Quarter-period timebase: one-cycle tick every CLK_DIV cycles and a
// free-wrapping 2-bit quarter index, both parked at zero while held.
module i2c_qtick #(
  parameter int CLK_DIV = 125
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    quarter_reg;

  assign tick    = !hold && (cnt_reg == CW'(CLK_DIV - 1));
  assign quarter = quarter_reg;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      quarter_reg <= 2'd0;
    end else if (hold) begin
      cnt_reg     <= '0;
      quarter_reg <= 2'd0;
    end else if (tick) begin
      cnt_reg     <= '0;
      quarter_reg <= quarter_reg + 2'd1;
    end else begin
      cnt_reg     <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_reg_writer.sv
// I2C master that writes one register: START, address+W, register bytes,
// data bytes, STOP; checks every ACK and retries the whole frame on NACK.
module i2c_reg_writer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV     = 125,
  parameter int REG_BYTES   = 1,
  parameter int DATA_BYTES  = 1,
  parameter int MAX_RETRIES = 2
) (
  input  logic               sys_clk,
  input  logic               rst,
  i2c_reg_writer_if.master   bus
);

  localparam int N  = frame_bytes(REG_BYTES, DATA_BYTES);
  localparam int IW = $clog2(N);

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [IW-1:0] byte_idx_reg, byte_idx_next;
  logic [2:0]    retry_reg, retry_next;
  logic          nack_reg, nack_next;
  logic          error_reg, error_next;

  logic [7:0]    frame_in  [N];
  logic [7:0]    frame_reg [N];

  logic          tick;
  logic [1:0]    quarter;
  logic          qhold;
  logic          phase_end;
  logic          accept;
  logic          last_byte;
  logic          cur_bit;
  logic          scl_oe_c;
  logic          sda_oe_c;

  // Frame laid out in transmit order; multi-byte fields go MSB first.
  assign frame_in[0] = {bus.dev_addr, W_BIT};

  generate
    for (genvar gi = 0; gi < REG_BYTES; gi++) begin : g_reg_bytes
      assign frame_in[1 + gi] = bus.reg_addr[8*(REG_BYTES-1-gi) +: 8];
    end
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_data_bytes
      assign frame_in[1 + REG_BYTES + gi] = bus.wdata[8*(DATA_BYTES-1-gi) +: 8];
    end
  endgenerate

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      frame_reg <= frame_in;
    end
  end

  // Timebase restarts from zero so START always gets full quarters.
  assign qhold = (state_reg == IDLE) || (state_reg == DONE);

  i2c_qtick #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .sys_clk (sys_clk),
    .rst     (rst),
    .hold    (qhold),
    .tick    (tick),
    .quarter (quarter)
  );

  assign phase_end = tick && (quarter == Q3);
  assign accept    = (state_reg == IDLE) && bus.start;
  assign last_byte = (byte_idx_reg == IW'(N - 1));
  assign cur_bit   = frame_reg[byte_idx_reg][3'd7 - bit_cnt_reg];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      byte_idx_reg <= '0;
      retry_reg    <= 3'd0;
      nack_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_idx_reg <= byte_idx_next;
      retry_reg    <= retry_next;
      nack_reg     <= nack_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_idx_next = byte_idx_reg;
    retry_next    = retry_reg;
    nack_next     = nack_reg;
    error_next    = error_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next    = START;
          bit_cnt_next  = 3'd0;
          byte_idx_next = '0;
          retry_next    = 3'd0;
          nack_next     = 1'b0;
          error_next    = 1'b0;
        end
      end
      START: begin
        if (phase_end) begin
          state_next = BIT;
        end
      end
      BIT: begin
        if (phase_end) begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = ACK;
          end
        end
      end
      ACK: begin
        // Sample on the last cycle of the SCL-high third quarter.
        if (tick && (quarter == Q2)) begin
          nack_next = bus.sda_in;
        end
        if (phase_end) begin
          if (nack_reg || last_byte) begin
            state_next = STOP;
          end else begin
            state_next    = BIT;
            byte_idx_next = byte_idx_reg + IW'(1);
          end
        end
      end
      STOP: begin
        if (phase_end) begin
          if (nack_reg && (retry_reg < 3'(MAX_RETRIES))) begin
            state_next    = START;
            retry_next    = retry_reg + 3'd1;
            byte_idx_next = '0;
            bit_cnt_next  = 3'd0;
            nack_next     = 1'b0;
          end else begin
            state_next = DONE;
            error_next = nack_reg;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pad enables decoded from state and quarter; every bit is low, low, high, high.
  always_comb begin
    scl_oe_c = 1'b0;
    sda_oe_c = 1'b0;
    case (state_reg)
      START: begin
        case (quarter)
          Q0:      begin scl_oe_c = 1'b0; sda_oe_c = 1'b0; end
          Q1:      begin scl_oe_c = 1'b0; sda_oe_c = 1'b1; end
          default: begin scl_oe_c = 1'b1; sda_oe_c = 1'b1; end
        endcase
      end
      BIT: begin
        scl_oe_c = ~quarter[1];
        sda_oe_c = ~cur_bit;
      end
      ACK: begin
        scl_oe_c = ~quarter[1];
        sda_oe_c = 1'b0;
      end
      STOP: begin
        case (quarter)
          Q0, Q1:  begin scl_oe_c = 1'b1; sda_oe_c = 1'b1; end
          Q2:      begin scl_oe_c = 1'b0; sda_oe_c = 1'b1; end
          Q3:      begin scl_oe_c = 1'b0; sda_oe_c = 1'b0; end
          default: begin scl_oe_c = 1'b0; sda_oe_c = 1'b0; end
        endcase
      end
      default: begin
        scl_oe_c = 1'b0;
        sda_oe_c = 1'b0;
      end
    endcase
  end

  assign bus.scl_oe = scl_oe_c;
  assign bus.sda_oe = sda_oe_c;
  assign bus.busy   = (state_reg == START) || (state_reg == BIT) ||
                      (state_reg == ACK)   || (state_reg == STOP);
  assign bus.done   = (state_reg == DONE);
  assign bus.error  = error_reg;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Directed bench for i2c_reg_writer: two configurations, a bus monitor that
// decodes START/STOP/bytes and a slave that ACKs or NACKs chosen bytes.
module tb_i2c_reg_writer;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  always #5 sys_clk = ~sys_clk;

  i2c_reg_writer_if #(.REG_BYTES(1), .DATA_BYTES(1)) a_if ();
  i2c_reg_writer_if #(.REG_BYTES(2), .DATA_BYTES(4)) b_if ();

  i2c_reg_writer #(
    .CLK_DIV(4), .REG_BYTES(1), .DATA_BYTES(1), .MAX_RETRIES(2)
  ) dut_a (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (a_if.master)
  );

  i2c_reg_writer #(
    .CLK_DIV(4), .REG_BYTES(2), .DATA_BYTES(4), .MAX_RETRIES(1)
  ) dut_b (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (b_if.master)
  );

  int tests = 0;
  int fails = 0;

  // Bus lines: open-drain wired-AND of the selected DUT and the slave model.
  logic sel        = 1'b0;
  logic slave_pull = 1'b0;
  logic scl_a, sda_a, scl_b, sda_b, scl_l, sda_l;

  assign scl_a       = ~a_if.scl_oe;
  assign sda_a       = ~(a_if.sda_oe | (~sel & slave_pull));
  assign scl_b       = ~b_if.scl_oe;
  assign sda_b       = ~(b_if.sda_oe | (sel & slave_pull));
  assign a_if.sda_in = sda_a;
  assign b_if.sda_in = sda_b;
  assign scl_l       = sel ? scl_b : scl_a;
  assign sda_l       = sel ? sda_b : sda_a;

  logic       scl_p      = 1'b1;
  logic       sda_p      = 1'b1;
  int         start_cnt  = 0;
  int         stop_cnt   = 0;
  int         bitcnt     = 0;
  int         byte_idx   = 0;
  int         nack_byte  = -1;
  int         nack_until = 0;
  logic [7:0] shreg      = 8'h00;
  logic [7:0] cap [$];
  int         done_a_cnt = 0;
  int         done_b_cnt = 0;

  always @(posedge sys_clk) begin
    scl_p <= scl_l;
    sda_p <= sda_l;
    if (rst) begin
      bitcnt     <= 0;
      byte_idx   <= 0;
      slave_pull <= 1'b0;
    end else if (scl_p && scl_l && sda_p && !sda_l) begin
      start_cnt  <= start_cnt + 1;
      bitcnt     <= 0;
      byte_idx   <= 0;
      slave_pull <= 1'b0;
    end else if (scl_p && scl_l && !sda_p && sda_l) begin
      stop_cnt <= stop_cnt + 1;
    end else if (!scl_p && scl_l) begin
      if (bitcnt < 8) begin
        shreg <= {shreg[6:0], sda_l};
        if (bitcnt == 7) cap.push_back({shreg[6:0], sda_l});
      end
      bitcnt <= bitcnt + 1;
    end else if (scl_p && !scl_l) begin
      if (bitcnt == 8) begin
        slave_pull <= !((byte_idx == nack_byte) && (start_cnt <= nack_until));
      end else if (bitcnt == 9) begin
        slave_pull <= 1'b0;
        bitcnt     <= 0;
        byte_idx   <= byte_idx + 1;
      end
    end
  end

  always @(posedge sys_clk) begin
    if (a_if.done) done_a_cnt <= done_a_cnt + 1;
    if (b_if.done) done_b_cnt <= done_b_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int base, input int n, input logic [63:0] exp);
    logic [63:0] obs;
    chk({tag, "_count"}, 64'(cap.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      obs = (base + i < cap.size()) ? 64'(cap[base + i]) : 64'hDEAD;
      chk($sformatf("%s_byte%0d", tag, i), obs, 64'(exp[8*(n-1-i) +: 8]));
    end
  endtask

  task automatic run_txn(input string tag, input bit use_b, input logic [6:0] dev,
                         input logic [15:0] ra, input logic [31:0] wd, input int hold,
                         output int cyc, output logic err, output logic acc_err,
                         output logic acc_busy);
    logic seen;
    @(negedge sys_clk);
    if (use_b) begin
      b_if.dev_addr = dev; b_if.reg_addr = ra; b_if.wdata = wd; b_if.start = 1'b1;
    end else begin
      a_if.dev_addr = dev; a_if.reg_addr = ra[7:0]; a_if.wdata = wd[7:0]; a_if.start = 1'b1;
    end
    @(posedge sys_clk); #1;
    acc_err  = use_b ? b_if.error : a_if.error;
    acc_busy = use_b ? b_if.busy  : a_if.busy;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      if (cyc >= hold) begin
        a_if.start = 1'b0;
        b_if.start = 1'b0;
      end
      @(posedge sys_clk); #1;
      cyc++;
      seen = use_b ? b_if.done : a_if.done;
    end
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    err = use_b ? b_if.error : a_if.error;
  endtask

  initial begin
    int   cyc, s0, p0, d0, b0;
    logic err, acc_err, acc_busy;

    a_if.start = 1'b0; a_if.dev_addr = '0; a_if.reg_addr = '0; a_if.wdata = '0;
    b_if.start = 1'b0; b_if.dev_addr = '0; b_if.reg_addr = '0; b_if.wdata = '0;

    // Reset state
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_a_scl_oe", 64'(a_if.scl_oe), 64'd0);
    chk("rst_a_sda_oe", 64'(a_if.sda_oe), 64'd0);
    chk("rst_a_busy",   64'(a_if.busy),   64'd0);
    chk("rst_a_done",   64'(a_if.done),   64'd0);
    chk("rst_a_error",  64'(a_if.error),  64'd0);
    chk("rst_b_busy",   64'(b_if.busy),   64'd0);
    rst = 1'b0;
    repeat (3) @(posedge sys_clk);

    // T1: basic 1+1 byte write, all ACK
    sel = 1'b0; nack_byte = -1;
    s0 = start_cnt; p0 = stop_cnt; d0 = done_a_cnt; b0 = cap.size();
    run_txn("t1", 1'b0, 7'h1A, 16'h000E, 32'h55, 0, cyc, err, acc_err, acc_busy);
    chk("t1_busy_after_accept", 64'(acc_busy), 64'd1);
    chk("t1_cycles", 64'(cyc), 64'd464);
    chk("t1_error", 64'(err), 64'd0);
    repeat (3) @(posedge sys_clk); #1;
    chk("t1_busy_idle", 64'(a_if.busy), 64'd0);
    chk("t1_done_idle", 64'(a_if.done), 64'd0);
    chk("t1_done_pulses", 64'(done_a_cnt - d0), 64'd1);
    chk("t1_starts", 64'(start_cnt - s0), 64'd1);
    chk("t1_stops", 64'(stop_cnt - p0), 64'd1);
    check_bytes("t1", b0, 3, 64'h340E55);

    // T2: 2 register bytes, 4 data bytes
    sel = 1'b1; nack_byte = -1;
    s0 = start_cnt; p0 = stop_cnt; d0 = done_b_cnt; b0 = cap.size();
    run_txn("t2", 1'b1, 7'h1A, 16'h1234, 32'hDEADBEEF, 0, cyc, err, acc_err, acc_busy);
    chk("t2_cycles", 64'(cyc), 64'd1040);
    chk("t2_error", 64'(err), 64'd0);
    repeat (3) @(posedge sys_clk); #1;
    chk("t2_done_pulses", 64'(done_b_cnt - d0), 64'd1);
    chk("t2_starts", 64'(start_cnt - s0), 64'd1);
    check_bytes("t2", b0, 7, 64'h0034_1234_DEAD_BEEF);

    // T3: address NACKed twice, third attempt succeeds
    sel = 1'b0; nack_byte = 0; nack_until = start_cnt + 2;
    s0 = start_cnt; p0 = stop_cnt; d0 = done_a_cnt; b0 = cap.size();
    run_txn("t3", 1'b0, 7'h1A, 16'h000E, 32'h55, 0, cyc, err, acc_err, acc_busy);
    chk("t3_cycles", 64'(cyc), 64'd816);
    chk("t3_error", 64'(err), 64'd0);
    repeat (3) @(posedge sys_clk); #1;
    chk("t3_starts", 64'(start_cnt - s0), 64'd3);
    chk("t3_stops", 64'(stop_cnt - p0), 64'd3);
    chk("t3_done_pulses", 64'(done_a_cnt - d0), 64'd1);
    check_bytes("t3", b0, 5, 64'h34_3434_0E55);
    nack_byte = -1;

    // T4: first data byte always NACKed, one retry, then error
    sel = 1'b1; nack_byte = 3; nack_until = 32'h7FFF_FFFF;
    s0 = start_cnt; p0 = stop_cnt; d0 = done_b_cnt; b0 = cap.size();
    run_txn("t4", 1'b1, 7'h1A, 16'h1234, 32'hDEADBEEF, 0, cyc, err, acc_err, acc_busy);
    chk("t4_cycles", 64'(cyc), 64'd1216);
    chk("t4_error", 64'(err), 64'd1);
    repeat (5) @(posedge sys_clk); #1;
    chk("t4_error_held", 64'(b_if.error), 64'd1);
    chk("t4_starts", 64'(start_cnt - s0), 64'd2);
    chk("t4_stops", 64'(stop_cnt - p0), 64'd2);
    chk("t4_done_pulses", 64'(done_b_cnt - d0), 64'd1);
    check_bytes("t4", b0, 8, 64'h341234DE_341234DE);
    nack_byte = -1;
    b0 = cap.size();
    run_txn("t4b", 1'b1, 7'h2B, 16'h00A7, 32'h01020304, 0, cyc, err, acc_err, acc_busy);
    chk("t4b_error_cleared", 64'(acc_err), 64'd0);
    chk("t4b_busy_after_accept", 64'(acc_busy), 64'd1);
    chk("t4b_cycles", 64'(cyc), 64'd1040);
    chk("t4b_error", 64'(err), 64'd0);
    check_bytes("t4b", b0, 7, 64'h0056_00A7_0102_0304);

    // T5: start held high for 300 cycles of a transfer
    sel = 1'b0;
    repeat (3) @(posedge sys_clk);
    s0 = start_cnt; p0 = stop_cnt; d0 = done_a_cnt; b0 = cap.size();
    run_txn("t5", 1'b0, 7'h7F, 16'h00FF, 32'h00, 300, cyc, err, acc_err, acc_busy);
    chk("t5_cycles", 64'(cyc), 64'd464);
    repeat (20) @(posedge sys_clk); #1;
    chk("t5_busy_idle", 64'(a_if.busy), 64'd0);
    chk("t5_done_pulses", 64'(done_a_cnt - d0), 64'd1);
    chk("t5_starts", 64'(start_cnt - s0), 64'd1);
    check_bytes("t5", b0, 3, 64'hFEFF00);

    // T6: reset in the middle of the address byte, then a clean transfer
    @(negedge sys_clk);
    a_if.dev_addr = 7'h1A; a_if.reg_addr = 8'h0E; a_if.wdata = 8'h55; a_if.start = 1'b1;
    @(posedge sys_clk); #1;
    a_if.start = 1'b0;
    repeat (82) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("t6_busy_before", 64'(a_if.busy), 64'd1);
    chk("t6_scl_oe_before", 64'(a_if.scl_oe), 64'd1);
    chk("t6_sda_oe_before", 64'(a_if.sda_oe), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_scl_oe_rst", 64'(a_if.scl_oe), 64'd0);
    chk("t6_sda_oe_rst", 64'(a_if.sda_oe), 64'd0);
    chk("t6_busy_rst", 64'(a_if.busy), 64'd0);
    chk("t6_done_rst", 64'(a_if.done), 64'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    repeat (4) @(posedge sys_clk);
    s0 = start_cnt; p0 = stop_cnt; d0 = done_a_cnt; b0 = cap.size();
    run_txn("t6", 1'b0, 7'h50, 16'h0081, 32'hA5, 0, cyc, err, acc_err, acc_busy);
    chk("t6_cycles", 64'(cyc), 64'd464);
    chk("t6_error", 64'(err), 64'd0);
    repeat (3) @(posedge sys_clk); #1;
    chk("t6_starts", 64'(start_cnt - s0), 64'd1);
    chk("t6_stops", 64'(stop_cnt - p0), 64'd1);
    chk("t6_done_pulses", 64'(done_a_cnt - d0), 64'd1);
    check_bytes("t6", b0, 3, 64'hA081A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
